// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and default sizes for the DRAM round-robin arbiter
// Contents: state_t (IDLE, ISSUE, WAIT, DONE); N_PORTS_DEF, AW_DEF, DW_DEF defaults.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int N_PORTS_DEF = 8;
    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 8;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick, first requester after ptr (mod N_PORTS)
// Ports: req  in  N_PORTS  request vector
//        ptr  in  PW       last granted port (lowest priority)
//        grant out PW      selected port index
//        valid out 1       any request present
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    localparam int PW = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [PW-1:0]      grant,
    output logic               valid
);
    logic [N_PORTS-1:0] rot;
    int off;
    // rot[j] is port ptr+1+j, so bit 0 holds the highest-priority port
    always_comb begin
        for (int j = 0; j < N_PORTS; j++) rot[j] = req[PW'((int'(ptr) + 1 + j) % N_PORTS)];
        off = 0;
        for (int j = N_PORTS - 1; j >= 0; j--) if (rot[j]) off = j;
        valid = |rot;
        grant = PW'((int'(ptr) + 1 + off) % N_PORTS);
    end
endmodule

// File: rtl/dram_rr_arbiter.sv
// dram_rr_arbiter: round-robin arbiter between N_PORTS cores and a single-port data RAM
// Ports: clk, rst_n (async active-low)
//        rden/wren  in  N_PORTS     per-core level requests, held until acq
//        addr/din   in  packed      per-core address / write data
//        ram_q      in  DW          RAM registered read data
//        acq        out N_PORTS     one-cycle completion pulse
//        dq         out N_PORTS*DW  per-core registered read data
//        ram_addr/ram_din/ram_wren  registered RAM controls
//        busy       out 1           request pending or FSM active
module dram_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int RAM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_PORTS-1:0]    rden,
    input  logic [N_PORTS-1:0]    wren,
    input  logic [N_PORTS*AW-1:0] addr,
    input  logic [N_PORTS*DW-1:0] din,
    input  logic [DW-1:0]         ram_q,
    output logic [N_PORTS-1:0]    acq,
    output logic [N_PORTS*DW-1:0] dq,
    output logic [AW-1:0]         ram_addr,
    output logic [DW-1:0]         ram_din,
    output logic                  ram_wren,
    output logic                  busy
);
    localparam int PW = $clog2(N_PORTS);
    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    state_t state, state_nx;
    logic [N_PORTS-1:0] req;
    logic [PW-1:0] ptr, g, grant;
    logic [CW-1:0] cnt;
    logic valid, is_wr;
    assign req  = rden | wren;
    assign busy = (|req) | (state != IDLE);
    rr_priority_picker #(.N_PORTS(N_PORTS)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .grant(grant),
        .valid(valid)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = valid ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (cnt == '0) ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    // cnt counts down to zero over RAM_LAT WAIT cycles; ram_q is valid in the last one,
    // so acq and the dq capture are registered together on the WAIT->DONE edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acq      <= '0;
            dq       <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wren <= 1'b0;
            ptr      <= PW'(N_PORTS - 1);
            g        <= '0;
            is_wr    <= 1'b0;
            cnt      <= '0;
        end else begin
            acq <= '0;
            case (state)
                IDLE: begin
                    ram_wren <= valid & wren[grant];
                    if (valid) begin
                        g        <= grant;
                        ptr      <= grant;
                        is_wr    <= wren[grant];
                        ram_addr <= addr[int'(grant)*AW +: AW];
                        ram_din  <= din[int'(grant)*DW +: DW];
                    end
                end
                ISSUE: begin
                    ram_wren <= 1'b0;
                    cnt      <= CW'(RAM_LAT - 1);
                end
                WAIT:
                    if (cnt == '0) begin
                        acq[g] <= 1'b1;
                        if (!is_wr) dq[int'(g)*DW +: DW] <= ram_q;
                    end else cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
endmodule

// File: tb/tb_dram_rr_arbiter.sv
// tb_dram_rr_arbiter: directed self-checking bench for dram_rr_arbiter with a behavioural RAM
module tb_dram_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rden = '0, wren = '0;
    logic [63:0] addr = '0, din = '0;
    logic [7:0]  ram_q;
    logic [7:0]  acq;
    logic [63:0] dq;
    logic [7:0]  ram_addr, ram_din;
    logic        ram_wren, busy;
    logic [7:0]  mem [256];
    logic [255:0] vld = '0;
    logic [63:0] exp_dq = '0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    // read-first RAM; unwritten locations read as addr ^ 8'hB5 (so 0x10 holds 0xA5)
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_din;
            vld[ram_addr] <= 1'b1;
        end
        ram_q <= vld[ram_addr] ? mem[ram_addr] : (ram_addr ^ 8'hB5);
    end

    dram_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n), .rden(rden), .wren(wren), .addr(addr), .din(din),
        .ram_q(ram_q), .acq(acq), .dq(dq), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_wren(ram_wren), .busy(busy)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        tick(2);
        chk("rst_acq", 64'(acq), 64'h0);
        chk("rst_dq", dq, 64'h0);
        chk("rst_ram_addr", 64'(ram_addr), 64'h0);
        chk("rst_ram_din", 64'(ram_din), 64'h0);
        chk("rst_ram_wren", 64'(ram_wren), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        // single read: core3 reads 0x10
        rden[3] = 1'b1;
        addr[24 +: 8] = 8'h10;
        tick(1);
        chk("rd_ram_addr", 64'(ram_addr), 64'h10);
        chk("rd_ram_wren", 64'(ram_wren), 64'h0);
        chk("rd_busy", 64'(busy), 64'h1);
        tick(1);
        chk("rd_acq_c2", 64'(acq), 64'h0);
        tick(1);
        exp_dq[24 +: 8] = 8'hA5;
        chk("rd_acq_c3", 64'(acq), 64'h08);
        chk("rd_dq", dq, exp_dq);
        rden = '0;
        tick(1);
        chk("rd_acq_c4", 64'(acq), 64'h0);
        chk("rd_idle_busy", 64'(busy), 64'h0);
        // write then read: core1 writes 0x3C to 0x22
        wren[1] = 1'b1;
        addr[8 +: 8] = 8'h22;
        din[8 +: 8] = 8'h3C;
        tick(1);
        chk("wr_ram_wren_c1", 64'(ram_wren), 64'h1);
        chk("wr_ram_addr", 64'(ram_addr), 64'h22);
        chk("wr_ram_din", 64'(ram_din), 64'h3C);
        tick(1);
        chk("wr_ram_wren_c2", 64'(ram_wren), 64'h0);
        chk("wr_mem", 64'(mem[8'h22]), 64'h3C);
        tick(1);
        chk("wr_acq", 64'(acq), 64'h02);
        chk("wr_dq_unch", dq, exp_dq);
        wren = '0;
        tick(1);
        rden[1] = 1'b1;
        tick(3);
        exp_dq[8 +: 8] = 8'h3C;
        chk("rb_acq", 64'(acq), 64'h02);
        chk("rb_dq", dq, exp_dq);
        rden = '0;
        tick(1);
        // all eight read at once from reset
        rst_n = 1'b0;
        #1;
        exp_dq = '0;
        chk("rst2_dq", dq, exp_dq);
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) addr[i*8 +: 8] = 8'(8'h40 + i);
        rden = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            tick(2);
            chk($sformatf("all_gap%0d", k), 64'(acq), 64'h0);
            tick(1);
            exp_dq[k*8 +: 8] = 8'(8'h40 + k) ^ 8'hB5;
            chk($sformatf("all_acq%0d", k), 64'(acq), 64'(8'h01 << k));
            chk($sformatf("all_dq%0d", k), dq, exp_dq);
            rden[k] = 1'b0;
            tick(1);
        end
        chk("all_busy_done", 64'(busy), 64'h0);
        chk("all_dq_final", dq, 64'hF2F3F0F1F6F7F4F5);
        // fairness: core0 holds its request, core5 arrives during core0's ISSUE
        rden[0] = 1'b1;
        addr[0 +: 8] = 8'h50;
        addr[40 +: 8] = 8'h55;
        tick(1);
        rden[5] = 1'b1;
        tick(2);
        exp_dq[0 +: 8] = 8'hE5;
        chk("fair_acq0", 64'(acq), 64'h01);
        tick(2);
        chk("fair_addr5", 64'(ram_addr), 64'h55);
        tick(2);
        exp_dq[40 +: 8] = 8'hE0;
        chk("fair_acq5", 64'(acq), 64'h20);
        chk("fair_dq5", dq, exp_dq);
        rden[5] = 1'b0;
        tick(4);
        chk("fair_acq0b", 64'(acq), 64'h01);
        rden = '0;
        tick(1);
        // core6 rden and wren both high: a write
        rden[6] = 1'b1;
        wren[6] = 1'b1;
        addr[48 +: 8] = 8'h66;
        din[48 +: 8] = 8'h99;
        tick(1);
        chk("rw_ram_wren", 64'(ram_wren), 64'h1);
        chk("rw_ram_addr", 64'(ram_addr), 64'h66);
        tick(2);
        chk("rw_acq", 64'(acq), 64'h40);
        chk("rw_dq_unch", dq, exp_dq);
        chk("rw_mem", 64'(mem[8'h66]), 64'h99);
        rden = '0;
        wren = '0;
        tick(1);
        // reset during WAIT, then a pending core2 read completes
        rden[2] = 1'b1;
        addr[16 +: 8] = 8'h70;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("wrst_acq", 64'(acq), 64'h0);
        chk("wrst_ram_wren", 64'(ram_wren), 64'h0);
        chk("wrst_ram_addr", 64'(ram_addr), 64'h0);
        chk("wrst_dq", dq, 64'h0);
        rden = '0;
        #1;
        chk("wrst_idle", 64'(busy), 64'h0);
        rden[2] = 1'b1;
        tick(1);
        rst_n = 1'b1;
        exp_dq = '0;
        tick(2);
        chk("post_acq_c2", 64'(acq), 64'h0);
        tick(1);
        exp_dq[16 +: 8] = 8'hC5;
        chk("post_acq_c3", 64'(acq), 64'h04);
        chk("post_dq", dq, exp_dq);
        rden = '0;
        tick(1);
        chk("post_busy", 64'(busy), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
